// File: rtl/s2u_dma_rd_sched.sv
// s2u_dma_rd_sched: system-to-user stream DMA read scheduler.
// On each rising edge of the stream enable, the host buffer is split into
// memory-read requests of at most MAX_RD_BYTES. Each request gets a unique
// tag from a free-tag pool. The block raises done once every completion
// has returned.
// Optional feature macro: S2U_RD_4K_SPLIT_EN. When it is defined, requests
// are also truncated so that none of them crosses a 4 KB host boundary.

module s2u_dma_rd_sched #(
   parameter int MAX_RD_BYTES = 512,
   parameter int TAG_W        = 3
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             i_str_en,
   input  logic [31:0]      i_dma_addr,
   input  logic [31:0]      i_dma_len,
   output logic             o_done,
   input  logic             i_done_ack,
   output logic             o_busy,
   output logic             o_rd_req,
   input  logic             i_rd_ack,
   output logic [31:0]      o_rd_addr,
   output logic [12:0]      o_rd_len,
   output logic [TAG_W-1:0] o_rd_tag,
   input  logic             i_cpl_valid,
   input  logic [TAG_W-1:0] i_cpl_tag,
   input  logic             i_cpl_last
);

   localparam int NTAGS = 1 << TAG_W;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      REQ,
      DRAIN,
      DONE
   } state_e;

   state_e             state_q;
   logic [31:0]        addr_q;
   logic [31:0]        rem_q;
   logic [12:0]        chunk_q;
   logic [NTAGS-1:0]   tagBusy_q;
   logic               enDly_q;
   logic               abort_q;
   logic               done_q;
   logic               busy_q;
   logic               rdReq_q;
   logic [31:0]        rdAddr_q;
   logic [12:0]        rdLen_q;
   logic [TAG_W-1:0]   rdTag_q;

   logic [12:0]        chunk_d;
   logic [TAG_W-1:0]   freeTag;
   logic               poolFull;
   logic [NTAGS-1:0]   tagSet;
   logic [NTAGS-1:0]   tagClr;
   logic [NTAGS-1:0]   tagBusy_d;
   logic               reqAccepted;

   assign o_done    = done_q;
   assign o_busy    = busy_q;
   assign o_rd_req  = rdReq_q;
   assign o_rd_addr = rdAddr_q;
   assign o_rd_len  = rdLen_q;
   assign o_rd_tag  = rdTag_q;

   assign reqAccepted = rdReq_q & i_rd_ack;
   assign poolFull    = &tagBusy_q;

`ifdef S2U_RD_4K_SPLIT_EN
   logic [12:0]        boundLim;
`endif

   // Next chunk size: the smallest of remaining bytes, the max request size and, optionally, the distance to the next 4 KB boundary.
   always_comb begin
      chunk_d = (rem_q > 32'(MAX_RD_BYTES)) ? 13'(MAX_RD_BYTES) : rem_q[12:0];
`ifdef S2U_RD_4K_SPLIT_EN
      boundLim = 13'd4096 - {1'b0, addr_q[11:0]};
      if (boundLim < chunk_d) begin
         chunk_d = boundLim;
      end
`endif
   end

   // Pick the lowest-index free tag. This scan goes from the top down, so the lowest free index is the last one written.
   always_comb begin
      freeTag = '0;
      for (int i = NTAGS - 1; i >= 0; i--) begin
         if (!tagBusy_q[i]) begin
            freeTag = TAG_W'(i);
         end
      end
   end

   // Tag bitmap update. A tag allocated this cycle stays busy even if a completion for the same index arrives in that cycle.
   always_comb begin
      tagClr    = (i_cpl_valid & i_cpl_last) ? ({{(NTAGS-1){1'b0}}, 1'b1} << i_cpl_tag) : '0;
      tagSet    = reqAccepted ? ({{(NTAGS-1){1'b0}}, 1'b1} << rdTag_q) : '0;
      tagBusy_d = (tagBusy_q & ~tagClr) | tagSet;
   end

   // Main scheduler FSM. All outputs are registered here.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         chunk_q   <= '0;
         tagBusy_q <= '0;
         enDly_q   <= 1'b0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         rdReq_q   <= 1'b0;
         rdAddr_q  <= '0;
         rdLen_q   <= '0;
         rdTag_q   <= '0;
      end else begin
         enDly_q   <= i_str_en;
         tagBusy_q <= tagBusy_d;
         case (state_q)
            IDLE: begin
               if (i_str_en && !enDly_q) begin
                  addr_q  <= i_dma_addr & 32'hFFFF_FFFC;
                  rem_q   <= i_dma_len & 32'hFFFF_FFFC;
                  abort_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= (i_dma_len[31:2] == 30'd0) ? DONE : CALC;
               end
            end
            CALC: begin
               if (!i_str_en) begin
                  abort_q <= 1'b1;
                  state_q <= DRAIN;
               end else begin
                  chunk_q <= chunk_d;
                  state_q <= REQ;
                  if (!poolFull) begin
                     rdReq_q  <= 1'b1;
                     rdAddr_q <= addr_q;
                     rdLen_q  <= chunk_d;
                     rdTag_q  <= freeTag;
                  end
               end
            end
            REQ: begin
               if (reqAccepted) begin
                  rdReq_q <= 1'b0;
                  addr_q  <= addr_q + {19'd0, chunk_q};
                  rem_q   <= rem_q - {19'd0, chunk_q};
                  state_q <= (rem_q == {19'd0, chunk_q}) ? DRAIN : CALC;
               end else if (!i_str_en) begin
                  rdReq_q <= 1'b0;
                  abort_q <= 1'b1;
                  state_q <= DRAIN;
               end else if (!rdReq_q && !poolFull) begin
                  rdReq_q  <= 1'b1;
                  rdAddr_q <= addr_q;
                  rdLen_q  <= chunk_q;
                  rdTag_q  <= freeTag;
               end
            end
            DRAIN: begin
               if (tagBusy_q == '0) begin
                  if (abort_q) begin
                     abort_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               if (!done_q) begin
                  done_q <= 1'b1;
               end else if (i_done_ack) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s2u_dma_rd_sched.sv
// tb_s2u_dma_rd_sched: scoreboard bench for the DMA read scheduler.
// Expected requests are queued by the stimulus. A Tx-engine model accepts
// each request and checks it against the head of the queue.

module tb_s2u_dma_rd_sched;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_str_en = 1'b0;
   logic [31:0] i_dma_addr = '0;
   logic [31:0] i_dma_len = '0;
   logic        o_done;
   logic        i_done_ack = 1'b0;
   logic        o_busy;
   logic        o_rd_req;
   logic        i_rd_ack = 1'b0;
   logic [31:0] o_rd_addr;
   logic [12:0] o_rd_len;
   logic [2:0]  o_rd_tag;
   logic        i_cpl_valid = 1'b0;
   logic [2:0]  i_cpl_tag = '0;
   logic        i_cpl_last = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic [12:0] len;
      logic [2:0]  tag;
   } expReq_t;

   expReq_t expQ[$];
   int      errors = 0;
   int      checks = 0;
   int      reqCount = 0;
   int      ackBudget = 0;

   s2u_dma_rd_sched #(.MAX_RD_BYTES(512), .TAG_W(3)) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .i_str_en    (i_str_en),
      .i_dma_addr  (i_dma_addr),
      .i_dma_len   (i_dma_len),
      .o_done      (o_done),
      .i_done_ack  (i_done_ack),
      .o_busy      (o_busy),
      .o_rd_req    (o_rd_req),
      .i_rd_ack    (i_rd_ack),
      .o_rd_addr   (o_rd_addr),
      .o_rd_len    (o_rd_len),
      .o_rd_tag    (o_rd_tag),
      .i_cpl_valid (i_cpl_valid),
      .i_cpl_tag   (i_cpl_tag),
      .i_cpl_last  (i_cpl_last)
   );

   // Free-running 100 MHz bench clock
   always #5 clk_i = ~clk_i;

   // Single comparison point; every check goes through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Tx-engine model: accepts a pending request while the ack budget lasts and scores it against the queue
   always @(negedge clk_i) begin
      if (o_rd_req && ackBudget > 0) begin
         expReq_t e;
         i_rd_ack = 1'b1;
         ackBudget--;
         reqCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_req: got addr 0x%0h len 0x%0h tag %0d expected none", o_rd_addr, o_rd_len, o_rd_tag);
         end else begin
            e = expQ.pop_front();
            if (o_rd_addr !== e.addr || o_rd_len !== e.len || o_rd_tag !== e.tag) begin
               errors++;
               $display("[TB] FAIL req_fields: got 0x%0h/0x%0h/%0d expected 0x%0h/0x%0h/%0d",
                        o_rd_addr, o_rd_len, o_rd_tag, e.addr, e.len, e.tag);
            end
         end
      end else begin
         i_rd_ack = 1'b0;
      end
   end

   // Start a stream: program the address/length and raise the enable
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len);
      @(negedge clk_i);
      i_dma_addr = addr;
      i_dma_len  = len;
      i_str_en   = 1'b1;
   endtask

   task automatic pushExp(input logic [31:0] addr, input logic [12:0] len, input logic [2:0] tag);
      expReq_t e;
      e.addr = addr;
      e.len  = len;
      e.tag  = tag;
      expQ.push_back(e);
   endtask

   task automatic sendCpl(input logic [2:0] tag, input logic last);
      @(negedge clk_i);
      i_cpl_valid = 1'b1;
      i_cpl_tag   = tag;
      i_cpl_last  = last;
      @(negedge clk_i);
      i_cpl_valid = 1'b0;
      i_cpl_last  = 1'b0;
   endtask

   task automatic waitReqs(input int target);
      for (int i = 0; i < 200 && reqCount < target; i++) @(negedge clk_i);
      checkOutput("req_count", reqCount, target);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 200 && !o_done; i++) @(negedge clk_i);
      checkOutput("done_wait", {31'd0, o_done}, 32'd1);
   endtask

   // Acknowledge done and confirm it falls one cycle later, then close the stream
   task automatic ackDone();
      @(negedge clk_i);
      checkOutput("done_before_ack", {31'd0, o_done}, 32'd1);
      i_done_ack = 1'b1;
      @(negedge clk_i);
      i_done_ack = 1'b0;
      checkOutput("done_after_ack", {31'd0, o_done}, 32'd0);
      checkOutput("busy_after_ack", {31'd0, o_busy}, 32'd0);
      i_str_en = 1'b0;
      @(negedge clk_i);
   endtask

   // Hard time limit so the run can never hang
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int  base;
      logic sawDone;
      ackBudget = 1000;

      // Reset values
      repeat (3) @(negedge clk_i);
      checkOutput("rst_req", {31'd0, o_rd_req}, 32'd0);
      checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("rst_done", {31'd0, o_done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk_i);

      // Basic split into three 512-byte reads with latency and done timing
      pushExp(32'h1000_0000, 13'h200, 3'd0);
      pushExp(32'h1000_0200, 13'h200, 3'd1);
      pushExp(32'h1000_0400, 13'h200, 3'd2);
      applyStimulus(32'h1000_0000, 32'h600);
      @(negedge clk_i);
      checkOutput("lat_req_calc", {31'd0, o_rd_req}, 32'd0);
      checkOutput("lat_busy", {31'd0, o_busy}, 32'd1);
      @(negedge clk_i);
      checkOutput("lat_req_high", {31'd0, o_rd_req}, 32'd1);
      waitReqs(3);
      sendCpl(3'd0, 1'b1);
      sendCpl(3'd1, 1'b1);
      checkOutput("basic_done_early", {31'd0, o_done}, 32'd0);
      sendCpl(3'd2, 1'b1);
      @(negedge clk_i);
      checkOutput("basic_done_m1", {31'd0, o_done}, 32'd0);
      @(negedge clk_i);
      checkOutput("basic_done_m2", {31'd0, o_done}, 32'd1);
      ackDone();
      checkOutput("basic_sb_empty", expQ.size(), 0);

      // 4 KB boundary case; the low address and length bits are ignored
      base = reqCount;
`ifdef S2U_RD_4K_SPLIT_EN
      pushExp(32'h0000_0F80, 13'h080, 3'd0);
      pushExp(32'h0000_1000, 13'h180, 3'd1);
      applyStimulus(32'h0000_0F82, 32'h201);
      waitReqs(base + 2);
      sendCpl(3'd0, 1'b1);
      sendCpl(3'd1, 1'b1);
`else
      pushExp(32'h0000_0F80, 13'h200, 3'd0);
      applyStimulus(32'h0000_0F82, 32'h201);
      waitReqs(base + 1);
      sendCpl(3'd0, 1'b1);
`endif
      waitDone();
      ackDone();
      checkOutput("split_sb_empty", expQ.size(), 0);

      // Pool exhaustion: eight tags in flight, then the ninth waits for a free tag
      base = reqCount;
      for (int i = 0; i < 8; i++) pushExp(32'h2000_0000 + 32'(i) * 32'h200, 13'h200, 3'(i));
      applyStimulus(32'h2000_0000, 32'h1200);
      waitReqs(base + 8);
      repeat (10) @(negedge clk_i);
      checkOutput("pool_full_req", {31'd0, o_rd_req}, 32'd0);
      pushExp(32'h2000_1000, 13'h200, 3'd3);
      sendCpl(3'd3, 1'b1);
      checkOutput("pool_free_req_low", {31'd0, o_rd_req}, 32'd0);
      @(negedge clk_i);
      checkOutput("pool_free_req_high", {31'd0, o_rd_req}, 32'd1);
      waitReqs(base + 9);
      for (int i = 0; i < 8; i++) sendCpl(3'(i), 1'b1);
      waitDone();
      ackDone();
      checkOutput("pool_sb_empty", expQ.size(), 0);

      // Out-of-order completions, a spurious completion and a non-final beat
      base = reqCount;
      pushExp(32'h3000_0000, 13'h200, 3'd0);
      pushExp(32'h3000_0200, 13'h200, 3'd1);
      pushExp(32'h3000_0400, 13'h200, 3'd2);
      applyStimulus(32'h3000_0000, 32'h600);
      waitReqs(base + 3);
      sendCpl(3'd5, 1'b1);
      sendCpl(3'd0, 1'b0);
      sendCpl(3'd2, 1'b1);
      repeat (3) @(negedge clk_i);
      checkOutput("ooo_done_a", {31'd0, o_done}, 32'd0);
      sendCpl(3'd0, 1'b1);
      repeat (3) @(negedge clk_i);
      checkOutput("ooo_done_b", {31'd0, o_done}, 32'd0);
      checkOutput("ooo_busy", {31'd0, o_busy}, 32'd1);
      sendCpl(3'd1, 1'b1);
      waitDone();
      ackDone();

      // Zero length goes straight to done with no request
      base = reqCount;
      applyStimulus(32'h4000_0000, 32'h0);
      @(negedge clk_i);
      checkOutput("zero_done_n1", {31'd0, o_done}, 32'd0);
      checkOutput("zero_busy_n1", {31'd0, o_busy}, 32'd1);
      @(negedge clk_i);
      checkOutput("zero_done_n2", {31'd0, o_done}, 32'd1);
      ackDone();
      checkOutput("zero_no_req", reqCount, base);

      // Abort with two tags busy and a third request pending
      base = reqCount;
      ackBudget = 2;
      pushExp(32'h5000_0000, 13'h200, 3'd0);
      pushExp(32'h5000_0200, 13'h200, 3'd1);
      applyStimulus(32'h5000_0000, 32'h1000);
      waitReqs(base + 2);
      for (int i = 0; i < 20 && !o_rd_req; i++) @(negedge clk_i);
      checkOutput("abort_pending", {31'd0, o_rd_req}, 32'd1);
      i_str_en = 1'b0;
      @(negedge clk_i);
      checkOutput("abort_req_drop", {31'd0, o_rd_req}, 32'd0);
      checkOutput("abort_busy", {31'd0, o_busy}, 32'd1);
      sawDone = 1'b0;
      sendCpl(3'd0, 1'b1);
      sendCpl(3'd1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (o_done) sawDone = 1'b1;
      end
      checkOutput("abort_no_done", {31'd0, sawDone}, 32'd0);
      checkOutput("abort_idle", {31'd0, o_busy}, 32'd0);
      ackBudget = 1000;

      // Asynchronous reset while a request is pending and one tag is busy
      base = reqCount;
      ackBudget = 1;
      pushExp(32'h6000_0000, 13'h200, 3'd0);
      applyStimulus(32'h6000_0000, 32'h400);
      waitReqs(base + 1);
      for (int i = 0; i < 20 && !o_rd_req; i++) @(negedge clk_i);
      checkOutput("rst_mid_pending", {31'd0, o_rd_req}, 32'd1);
      #2;
      rst_n    = 1'b0;
      i_str_en = 1'b0;
      #1;
      checkOutput("arst_req", {31'd0, o_rd_req}, 32'd0);
      checkOutput("arst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("arst_done", {31'd0, o_done}, 32'd0);
      @(negedge clk_i);
      rst_n = 1'b1;
      ackBudget = 1000;
      base = reqCount;
      pushExp(32'h7000_0000, 13'h200, 3'd0);
      applyStimulus(32'h7000_0000, 32'h200);
      waitReqs(base + 1);
      sendCpl(3'd0, 1'b1);
      waitDone();
      ackDone();

      checkOutput("final_sb_empty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
